order_ingress_queue: RTL and testbench
======================================

Name: order_ingress_queue

Overview:
Buffers incoming 32-bit order words from the packet/command parser and releases them one at a time to the matching engine (order_book_top). It uses the engine's busy handshake: a one-cycle valid pulse, then wait for busy to rise and fall. It filters zero-quantity orders, counts drops, and recovers if the engine never acknowledges an order.

Parameters:
DEPTH, 16, FIFO entries; power of two, ≥2
ADDR_W, 4, log2(DEPTH)
ACK_TIMEOUT, 8, cycles to wait for engine_busy to rise after an issue pulse
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream order word valid
s_ready  out  1  upstream may transfer; equals !fifo_full
s_data  in  32  order word: price[31:16], side[15] (1=buy), bot_id[14], qty[13:0]
engine_busy  in  1  matching engine busy flag
ord_valid  out  1  one-cycle issue pulse to the engine's input_valid
ord_data  out  32  order word to the engine's input_data; held stable between issues
fifo_level  out  ADDR_W+1  current occupancy, 0..DEPTH
fifo_full  out  1  level==DEPTH
fifo_empty  out  1  level==0
drop_count  out  CNT_W  zero-qty orders discarded; saturates at all-ones
timeout_count  out  CNT_W  issue pulses not acknowledged in time; saturates

Behaviour:
- Reset (async assert, sync release):
  - s_ready=1, ord_valid=0, ord_data=0, fifo_level=0, fifo_empty=1, fifo_full=0
  - Both counters 0; FSM=IDLE; read and write pointers 0.
- Accept when s_valid&&s_ready at a rising edge:
  - If s_data[13:0]==0: the word is consumed, not stored, and drop_count increments.
  - Otherwise the word is written at wr_ptr and wr_ptr increments modulo DEPTH.
- s_ready and fifo_full come from registered state. A pop in the same cycle does not raise s_ready until the next cycle. Writes are never lost, and the FIFO never overflows.
- A simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if !fifo_empty && !engine_busy, at the edge:
  - load ord_data from the head and advance rd_ptr
  - set ord_valid=1 and go to ISSUE.
- ISSUE: lasts exactly one cycle. ord_valid=1 during it; at the edge, ord_valid→0, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - engine_busy==1 → WAIT_DONE.
  - Else the counter increments. When it reaches ACK_TIMEOUT with busy still low: timeout_count++, go to IDLE. The order is considered delivered and is not reissued.
- WAIT_DONE: engine_busy==0 → IDLE.
- Latency: with the FIFO empty, FSM in IDLE and engine idle, a word accepted at edge N gives ord_valid high during cycle N+1→N+2. Minimum spacing between issues is 4 cycles.
- ord_valid is never high for two consecutive cycles. At most one order is outstanding.
- Word format passes through bit-exact with no reordering. FIFO order is strict.
- Pointer wrap: ADDR_W-bit pointers wrap naturally. The level is tracked separately, so full and empty are distinguished.
- Counters saturate and do not wrap.
- Reset mid-operation: state is abandoned immediately; ord_valid drops asynchronously. A half-issued order is lost.

Test Plan:
- Single order, timing: push 0x0066_4032 (ask 102, bot, qty 50), engine idle → ord_valid exactly one cycle at N+1→N+2, ord_data=0x0066_4032. Model busy high 1 cycle later for 3 cycles → FSM back to IDLE, fifo_level=0.
- Ordering under backpressure: hold engine_busy=1 and push 5 orders, qty 1..5 → fifo_level=5 and no ord_valid. Release busy → 5 pulses in push order, each spaced ≥4 cycles, each waiting for the busy round-trip.
- Full/overflow: busy held, push 20 words back-to-back → 16 accepted, s_ready=0 and fifo_full=1 after the 16th, level=16. Drain one → s_ready rises the following cycle.
- Zero-qty filter: push 0x0064_8000 (buy 100, qty 0), then 0x0064_800A → drop_count=1, only 0x0064_800A issued.
- Timeout: engine never raises busy → after 1 issue + 8 cycles, timeout_count=1. The next queued order is then issued; the first is not repeated.
- Reset mid-flight: assert rst_n=0 during WAIT_DONE with 3 queued → all outputs at reset values immediately; no issue after release until a new push.

Source files
------------

// File: rtl/order_ingress_queue.sv
// order_ingress_queue: buffers 32-bit order words from the parser and releases
// them one at a time to the matching engine using its valid-pulse / busy
// handshake. Zero-quantity orders are discarded and counted; an issue that the
// engine never acknowledges is abandoned after ACK_TIMEOUT cycles and counted.
module order_ingress_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              engine_busy,
  output logic              ord_valid,
  output logic [31:0]       ord_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   ACK_ONE  = {{(TO_W - 1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   ACK_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W - 1){1'b0}}, 1'b1};
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   level_nxt_s;
  logic              full_r;
  logic              empty_r;
  state_t            state_r;
  state_t            state_nxt_s;
  logic [TO_W-1:0]   ack_cnt_r;
  logic [TO_W-1:0]   ack_cnt_nxt_s;
  logic              ord_valid_r;
  logic [31:0]       ord_data_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  to_cnt_r;
  logic              accept_s;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;
  logic              timeout_s;

  // Full/empty are registered, so a same-cycle pop cannot open s_ready early.
  assign accept_s = s_valid & ~full_r;
  assign push_s   = accept_s & (s_data[13:0] != 14'd0);
  assign drop_s   = accept_s & (s_data[13:0] == 14'd0);

  assign s_ready       = ~full_r;
  assign fifo_full     = full_r;
  assign fifo_empty    = empty_r;
  assign fifo_level    = level_r;
  assign ord_valid     = ord_valid_r;
  assign ord_data      = ord_data_r;
  assign drop_count    = drop_cnt_r;
  assign timeout_count = to_cnt_r;

  // Next occupancy: push and pop together leave the level unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Issue FSM next-state: pop on issue, count the ack window, detect timeout.
  always_comb begin
    state_nxt_s   = state_r;
    ack_cnt_nxt_s = ack_cnt_r;
    pop_s         = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r && !engine_busy) begin
          pop_s       = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        ack_cnt_nxt_s = {TO_W{1'b0}};
        state_nxt_s   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (engine_busy) begin
          state_nxt_s = WAIT_DONE;
        end else if (ack_cnt_r == ACK_LAST) begin
          // Order treated as delivered; it is not reissued.
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ack_cnt_nxt_s = ack_cnt_r + ACK_ONE;
        end
      end
      WAIT_DONE: begin
        if (!engine_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and ack-window counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ack_cnt_r <= {TO_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ack_cnt_r <= ack_cnt_nxt_s;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W + 1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_FULL);
      empty_r <= (level_nxt_s == {(ADDR_W + 1){1'b0}});
    end
  end

  // Engine-facing outputs: one-cycle pulse, data held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_valid_r <= 1'b0;
      ord_data_r  <= 32'd0;
    end else begin
      ord_valid_r <= pop_s;
      if (pop_s) begin
        ord_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Saturating drop and timeout statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= {CNT_W{1'b0}};
      to_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
      if (timeout_s) begin
        to_cnt_r <= sat_inc(to_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_order_ingress_queue.sv
// Testbench for order_ingress_queue: directed stimulus, a scoreboard queue of
// expected issued words, a negedge monitor that checks each issue pulse, and a
// simple engine model that answers each pulse with a busy window.
module tb_order_ingress_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'd0;
  logic        engine_busy;
  logic        ord_valid;
  logic [31:0] ord_data;
  logic [4:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] drop_count;
  logic [15:0] timeout_count;

  order_ingress_queue #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .engine_busy(engine_busy), .ord_valid(ord_valid),
    .ord_data(ord_data), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int cyc = 0;
  int drive_cyc = 0;
  int pulse_cnt = 0;
  int last_issue_cyc = -1;
  logic prev_valid = 1'b0;

  // engine model controls
  logic force_busy = 1'b0;
  logic resp_busy = 1'b0;
  logic resp_pend = 1'b0;
  int   resp_left = 0;
  int   resp_len = 3;
  int   eng_mode = 0;   // 0: acknowledge every pulse, 1: never acknowledge

  assign engine_busy = force_busy | resp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // engine model: busy rises one cycle after a pulse and stays resp_len cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      resp_busy = 1'b0;
      resp_pend = 1'b0;
      resp_left = 0;
    end else begin
      if (resp_left > 0) begin
        resp_left = resp_left - 1;
        if (resp_left == 0) resp_busy = 1'b0;
      end else if (resp_pend) begin
        resp_pend = 1'b0;
        resp_busy = 1'b1;
        resp_left = resp_len;
      end
      if (ord_valid && eng_mode == 0) resp_pend = 1'b1;
    end
  end

  // monitor: every issue pulse is checked against the scoreboard
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (ord_valid) begin
      pulse_cnt = pulse_cnt + 1;
      tests = tests + 1;
      if (exp_q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_issue got %08h expected no issue", ord_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (ord_data !== exp_w) begin
          fails = fails + 1;
          $display("FAIL issue_data got %08h expected %08h", ord_data, exp_w);
        end
      end
      tests = tests + 1;
      if (prev_valid) begin
        fails = fails + 1;
        $display("FAIL pulse_width got 2+ cycles expected 1");
      end
      if (last_issue_cyc >= 0) begin
        tests = tests + 1;
        if (cyc - last_issue_cyc < 4) begin
          fails = fails + 1;
          $display("FAIL issue_spacing got %0d expected >=4", cyc - last_issue_cyc);
        end
      end
      last_issue_cyc = cyc;
    end
    prev_valid = ord_valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, output bit acc);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    acc = s_ready;
    drive_cyc = cyc;
    if (acc && d[13:0] != 14'd0) exp_q.push_back(d);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_valid = 1'b0;
    s_data = 32'd0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (pulse_cnt >= target) ok = 1'b1;
    end
    tests = tests + 1;
    if (!ok) begin
      fails = fails + 1;
      $display("FAIL wait_pulses got %0d expected %0d", pulse_cnt, target);
    end
  endtask

  task automatic wait_quiet(input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (pulse_cnt >= target && fifo_empty && !engine_busy && !resp_pend) ok = 1'b1;
    end
    tests = tests + 1;
    if (!ok) begin
      fails = fails + 1;
      $display("FAIL wait_quiet got %0d pulses expected %0d", pulse_cnt, target);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_ord_valid"}, 32'(ord_valid), 32'd0);
    chk({tag, "_ord_data"}, ord_data, 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, "_full"}, 32'(fifo_full), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_count), 32'd0);
    chk({tag, "_to_cnt"}, 32'(timeout_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int p0;
    int acc_n;
    int ia;
    logic [31:0] w;

    // reset values
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single order: latency and one-cycle pulse
    p0 = pulse_cnt;
    push(32'h0066_4032, acc);
    idle_in();
    wait_pulses(p0 + 1, 20);
    chk("t1_latency", 32'(last_issue_cyc - drive_cyc), 32'd2);
    wait_quiet(p0 + 1, 40);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_data_held", ord_data, 32'h0066_4032);

    // ordering under backpressure
    @(negedge clk);
    force_busy = 1'b1;
    p0 = pulse_cnt;
    for (int i = 1; i <= 5; i++) push(32'h0064_8000 | 32'(i), acc);
    idle_in();
    repeat (2) @(negedge clk);
    chk("t2_level", 32'(fifo_level), 32'd5);
    chk("t2_no_issue", 32'(pulse_cnt), 32'(p0));
    force_busy = 1'b0;
    wait_quiet(p0 + 5, 100);

    // full / overflow
    @(negedge clk);
    force_busy = 1'b1;
    p0 = pulse_cnt;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      push(32'h0080_0000 | 32'(i + 1), acc);
      if (acc) acc_n++;
    end
    idle_in();
    chk("t3_accepted", 32'(acc_n), 32'd16);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_s_ready_low", 32'(s_ready), 32'd0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("t3_drain_pulse", 32'(ord_valid), 32'd1);
    chk("t3_s_ready_rise", 32'(s_ready), 32'd1);
    chk("t3_level_15", 32'(fifo_level), 32'd15);
    wait_quiet(p0 + 16, 400);

    // zero-quantity filter
    p0 = pulse_cnt;
    push(32'h0064_8000, acc);
    chk("t4_drop_accepted", 32'(acc), 32'd1);
    push(32'h0064_800A, acc);
    idle_in();
    wait_quiet(p0 + 1, 60);
    chk("t4_drop_count", 32'(drop_count), 32'd1);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // ack timeout: engine never answers
    eng_mode = 1;
    p0 = pulse_cnt;
    push(32'h0065_0011, acc);
    push(32'h0065_0012, acc);
    idle_in();
    wait_pulses(p0 + 1, 20);
    ia = last_issue_cyc;
    wait_pulses(p0 + 2, 30);
    chk("t5_gap", 32'(last_issue_cyc - ia), 32'd10);
    chk("t5_to_count_1", 32'(timeout_count), 32'd1);
    repeat (15) @(posedge clk);
    chk("t5_to_count_2", 32'(timeout_count), 32'd2);
    chk("t5_pulses", 32'(pulse_cnt), 32'(p0 + 2));
    eng_mode = 0;
    repeat (2) @(posedge clk);

    // reset during WAIT_DONE with three orders queued
    resp_len = 10;
    for (int i = 1; i <= 4; i++) push(32'h0070_0000 | 32'(i), acc);
    idle_in();
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (fifo_level == 5'd3 && engine_busy) acc = 1'b1;
      else @(negedge clk);
    end
    chk("t6_reached_wait_done", 32'(acc), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_len = 3;
    p0 = pulse_cnt;
    repeat (20) @(posedge clk);
    chk("t6_no_issue", 32'(pulse_cnt), 32'(p0));
    chk("t6_level", 32'(fifo_level), 32'd0);
    w = 32'h0071_C007;
    push(w, acc);
    idle_in();
    wait_pulses(p0 + 1, 20);
    chk("t6_new_latency", 32'(last_issue_cyc - drive_cyc), 32'd2);
    wait_quiet(p0 + 1, 40);
    chk("t6_new_data", ord_data, w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
